alu_op_sequencer: RTL and testbench

Initiator-side driver for the team's combinational structural ALU: it accepts operation requests over a valid/ready handshake, drives the ALU operand and control inputs from registers, samples the ALU outputs one cycle later, and returns each result over a backpressured response channel. A sweep mode issues every operation code 0..2^OPERATION-1 on one operand set, replacing ad-hoc bench loops. It sits between a host or test controller and the ALU, and the ALU is its only timing path.

---
 rtl/alu_op_sequencer_if.sv | 91 +++++++++
 rtl/alu_op_sequencer.sv | 160 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request, sweep, ALU and response signals of alu_op_sequencer.
// slave: the sequencer; master: host plus the ALU it drives.
interface alu_op_sequencer_if #(
  parameter int OPERATION = 3,
  parameter int WIDTH     = 8,
  parameter int SHIFT     = 3
);

  logic                 req_valid;
  logic                 req_ready;
  logic [OPERATION-1:0] req_op;
  logic [SHIFT-1:0]     req_shamt;
  logic [WIDTH-1:0]     req_x;
  logic [WIDTH-1:0]     req_y;
  logic                 req_carry;

  logic                 sweep_start;
  logic                 sweep_busy;

  logic [OPERATION-1:0] alu_operation;
  logic [SHIFT-1:0]     alu_shamt;
  logic [WIDTH-1:0]     alu_x;
  logic [WIDTH-1:0]     alu_y;
  logic                 alu_carry_in;
  logic [WIDTH-1:0]     alu_result;
  logic                 alu_overflow;
  logic                 alu_zero;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [OPERATION-1:0] rsp_op;
  logic [WIDTH-1:0]     rsp_result;
  logic                 rsp_overflow;
  logic                 rsp_zero;
  logic                 rsp_last;

  modport master (
    output req_valid,
    input  req_ready,
    output req_op,
    output req_shamt,
    output req_x,
    output req_y,
    output req_carry,
    output sweep_start,
    input  sweep_busy,
    input  alu_operation,
    input  alu_shamt,
    input  alu_x,
    input  alu_y,
    input  alu_carry_in,
    output alu_result,
    output alu_overflow,
    output alu_zero,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_op,
    input  rsp_result,
    input  rsp_overflow,
    input  rsp_zero,
    input  rsp_last
  );

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_op,
    input  req_shamt,
    input  req_x,
    input  req_y,
    input  req_carry,
    input  sweep_start,
    output sweep_busy,
    output alu_operation,
    output alu_shamt,
    output alu_x,
    output alu_y,
    output alu_carry_in,
    input  alu_result,
    input  alu_overflow,
    input  alu_zero,
    output rsp_valid,
    input  rsp_ready,
    output rsp_op,
    output rsp_result,
    output rsp_overflow,
    output rsp_zero,
    output rsp_last
  );

endinterface

// File: rtl/alu_op_sequencer.sv
// Drives a combinational ALU from registers, one op per request or a full op sweep.
// Ports: clk, rst (async high), bus (alu_op_sequencer_if.slave: req/sweep/alu/rsp).
module alu_op_sequencer #(
  parameter int OPERATION = 3,
  parameter int WIDTH     = 8,
  parameter int SHIFT     = 3
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [OPERATION-1:0] LAST_OP = '1;

  logic [1:0]           state_q, state_d;
  logic [OPERATION-1:0] op_q, op_d;
  logic [SHIFT-1:0]     shamt_q, shamt_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic                 carry_q, carry_d;
  logic                 busy_q, busy_d;

  logic                 rvalid_q, rvalid_d;
  logic                 rlast_q, rlast_d;
  logic [OPERATION-1:0] rop_q, rop_d;
  logic [WIDTH-1:0]     rres_q, rres_d;
  logic                 rovf_q, rovf_d;
  logic                 rzero_q, rzero_d;

  logic in_idle;
  logic start_sweep;
  logic accept_req;
  logic rsp_fire;
  logic more_ops;

  assign in_idle     = (state_q == IDLE);
  assign start_sweep = in_idle && bus.sweep_start;
  assign accept_req  = in_idle && !bus.sweep_start
                       && bus.req_valid;
  assign rsp_fire    = (state_q == RESP) && bus.rsp_ready;
  assign more_ops    = busy_q && (op_q != LAST_OP);

  // Held low while rst is high so nothing is accepted in reset.
  assign bus.req_ready = in_idle && !bus.sweep_start && !rst;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    shamt_d = shamt_q;
    x_d     = x_q;
    y_d     = y_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rop_d    = rop_q;
    rres_d   = rres_q;
    rovf_d   = rovf_q;
    rzero_d  = rzero_q;

    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          start_sweep: begin
            op_d    = '0;
            shamt_d = bus.req_shamt;
            x_d     = bus.req_x;
            y_d     = bus.req_y;
            carry_d = bus.req_carry;
            busy_d  = 1'b1;
            state_d = DRIVE;
          end
          accept_req: begin
            op_d    = bus.req_op;
            shamt_d = bus.req_shamt;
            x_d     = bus.req_x;
            y_d     = bus.req_y;
            carry_d = bus.req_carry;
            state_d = DRIVE;
          end
          default: ;
        endcase
      end
      DRIVE: begin
        // ALU had a full cycle to settle.
        rres_d   = bus.alu_result;
        rovf_d   = bus.alu_overflow;
        rzero_d  = bus.alu_zero;
        rop_d    = op_q;
        rvalid_d = 1'b1;
        rlast_d  = busy_q && (op_q == LAST_OP);
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_fire) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (more_ops) begin
            op_d    = op_q + 1'b1;
            state_d = DRIVE;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      shamt_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rop_q    <= '0;
      rres_q   <= '0;
      rovf_q   <= 1'b0;
      rzero_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      shamt_q  <= shamt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      rop_q    <= rop_d;
      rres_q   <= rres_d;
      rovf_q   <= rovf_d;
      rzero_q  <= rzero_d;
    end
  end

  assign bus.sweep_busy    = busy_q;
  assign bus.alu_operation = op_q;
  assign bus.alu_shamt     = shamt_q;
  assign bus.alu_x         = x_q;
  assign bus.alu_y         = y_q;
  assign bus.alu_carry_in  = carry_q;
  assign bus.rsp_valid     = rvalid_q;
  assign bus.rsp_last      = rlast_q;
  assign bus.rsp_op        = rop_q;
  assign bus.rsp_result    = rres_q;
  assign bus.rsp_overflow  = rovf_q;
  assign bus.rsp_zero      = rzero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer driving a behavioural ALU.
// Tasks per scenario; expected responses queued at stimulus time.
module tb_alu_op_sequencer;

  localparam int OP = 3;
  localparam int W  = 8;
  localparam int SH = 3;

  typedef struct packed {
    logic [OP-1:0] op;
    logic [W-1:0]  res;
    logic          ovf;
    logic          zero;
    logic          last;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu_op_sequencer_if #(.OPERATION(OP), .WIDTH(W), .SHIFT(SH)) bus();

  alu_op_sequencer #(.OPERATION(OP), .WIDTH(W), .SHIFT(SH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: {overflow, zero, result}.
  function automatic logic [W+1:0] alu_ref(
    input logic [OP-1:0] op,
    input logic [SH-1:0] sh,
    input logic [W-1:0]  x,
    input logic [W-1:0]  y,
    input logic          c
  );
    logic [W-1:0] r;
    logic         v;
    v = 1'b0;
    case (op)
      3'd0: begin
        r = x + y + {{(W-1){1'b0}}, c};
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd1: begin
        r = x + ~y + {{(W-1){1'b0}}, c};
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x << sh;
      3'd6: r = x >> sh;
      default: r = ~x;
    endcase
    return {v, (r == '0), r};
  endfunction

  assign {bus.alu_overflow, bus.alu_zero, bus.alu_result} =
    alu_ref(bus.alu_operation, bus.alu_shamt,
            bus.alu_x, bus.alu_y, bus.alu_carry_in);

  function automatic exp_t mk_exp(
    input logic [OP-1:0] op,
    input logic [SH-1:0] sh,
    input logic [W-1:0]  x,
    input logic [W-1:0]  y,
    input logic          c,
    input logic          last
  );
    exp_t e;
    logic [W+1:0] a;
    a = alu_ref(op, sh, x, y, c);
    e.op   = op;
    e.res  = a[W-1:0];
    e.zero = a[W];
    e.ovf  = a[W+1];
    e.last = last;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_shamt = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_carry = 1'b0;
    bus.sweep_start = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.sweep_busy !== 1'b0
        || bus.rsp_last !== 1'b0 || bus.alu_operation !== 3'd0
        || bus.alu_x !== 8'h00 || bus.alu_y !== 8'h00)
      begin
        errors++;
        $display("FAIL reset_outputs got v=%b b=%b op=%0d x=%h need 0",
                 bus.rsp_valid, bus.sweep_busy,
                 bus.alu_operation, bus.alu_x);
      end
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b need 0", bus.req_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b need 1", bus.req_ready);
    end
  endtask

  task automatic test_single();
    exp_t e;
    bus.req_op = 3'd3;
    bus.req_x = 8'hFF;
    bus.req_y = 8'hFF;
    bus.req_shamt = 3'd4;
    bus.req_carry = 1'b1;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    sb.push_back(mk_exp(3'd3, 3'd4, 8'hFF, 8'hFF, 1'b1, 1'b0));
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.alu_operation !== 3'd3 || bus.alu_x !== 8'hFF
        || bus.alu_y !== 8'hFF || bus.alu_shamt !== 3'd4
        || bus.alu_carry_in !== 1'b1) begin
      errors++;
      $display("FAIL single_alu got op=%0d x=%h y=%h sh=%0d c=%b",
               bus.alu_operation, bus.alu_x, bus.alu_y,
               bus.alu_shamt, bus.alu_carry_in);
    end
    checks++;
    if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drive got rdy=%b v=%b need 0 0",
               bus.req_ready, bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency got v=%b need 1", bus.rsp_valid);
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.rsp_op !== e.op || bus.rsp_result !== e.res
          || bus.rsp_overflow !== e.ovf || bus.rsp_zero !== e.zero
          || bus.rsp_last !== e.last) begin
        errors++;
        $display("FAIL single_rsp got op=%0d r=%h need op=%0d r=%h",
                 bus.rsp_op, bus.rsp_result, e.op, e.res);
      end
    end
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready_resp got %b need 0", bus.req_ready);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_done got v=%b rdy=%b need 0 1",
               bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   n;
    bus.req_op = 3'd0;
    bus.req_x = 8'h7F;
    bus.req_y = 8'h01;
    bus.req_shamt = 3'd0;
    bus.req_carry = 1'b0;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b0;
    sb.push_back(mk_exp(3'd0, 3'd0, 8'h7F, 8'h01, 1'b0, 1'b0));
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout got v=%b need 1", bus.rsp_valid);
    end
    e = sb.pop_front();
    bus.req_valid = 1'b1;
    bus.req_op = 3'd2;
    bus.req_x = 8'h11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_op !== e.op
          || bus.rsp_result !== e.res || bus.rsp_overflow !== e.ovf
          || bus.rsp_zero !== e.zero || bus.req_ready !== 1'b0
          || bus.alu_x !== 8'h7F || bus.alu_operation !== 3'd0)
        begin
          errors++;
          $display("FAIL bp_hold[%0d] got v=%b r=%h o=%b x=%h need 1 %h %b 7f",
                   i, bus.rsp_valid, bus.rsp_result,
                   bus.rsp_overflow, bus.alu_x, e.res, e.ovf);
        end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1
        || bus.alu_x !== 8'h7F) begin
      errors++;
      $display("FAIL bp_release got v=%b rdy=%b x=%h need 0 1 7f",
               bus.rsp_valid, bus.req_ready, bus.alu_x);
    end
  endtask

  task automatic run_sweep(input string tag, input bit with_req);
    exp_t e;
    int   got, last_cyc, cyc;
    got = 0;
    last_cyc = 0;
    cyc = 0;
    bus.req_x = 8'h0F;
    bus.req_y = 8'hF0;
    bus.req_carry = 1'b0;
    bus.req_shamt = 3'd2;
    bus.req_op = 3'd5;
    bus.req_valid = with_req;
    bus.sweep_start = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++)
      sb.push_back(mk_exp(k[OP-1:0], 3'd2, 8'h0F, 8'hF0,
                          1'b0, k == 7));
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready got %b need 0", tag, bus.req_ready);
    end
    @(negedge clk);
    bus.sweep_start = 1'b0;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.sweep_busy !== 1'b1 || bus.alu_operation !== 3'd0) begin
      errors++;
      $display("FAIL %s_start got busy=%b op=%0d need 1 0",
               tag, bus.sweep_busy, bus.alu_operation);
    end
    while (got < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s_extra got op=%0d need none",
                   tag, bus.rsp_op);
        end else begin
          e = sb.pop_front();
          if (bus.rsp_op !== e.op || bus.rsp_result !== e.res
              || bus.rsp_overflow !== e.ovf
              || bus.rsp_zero !== e.zero
              || bus.rsp_last !== e.last) begin
            errors++;
            $display("FAIL %s_rsp got op=%0d r=%h l=%b need op=%0d r=%h l=%b",
                     tag, bus.rsp_op, bus.rsp_result, bus.rsp_last,
                     e.op, e.res, e.last);
          end
        end
        if (got > 0) begin
          checks++;
          if (cyc - last_cyc != 2) begin
            errors++;
            $display("FAIL %s_gap got %0d need 2",
                     tag, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
    end
    checks++;
    if (got != 8) begin
      errors++;
      $display("FAIL %s_count got %0d need 8", tag, got);
    end
    @(negedge clk);
    checks++;
    if (bus.sweep_busy !== 1'b0 || bus.rsp_valid !== 1'b0
        || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_end got busy=%b v=%b rdy=%b need 0 0 1",
               tag, bus.sweep_busy, bus.rsp_valid, bus.req_ready);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_sweep();
    run_sweep("sweep", 1'b0);
  endtask

  task automatic test_priority();
    run_sweep("prio", 1'b1);
  endtask

  task automatic test_reset_mid_sweep();
    int n, extra;
    bus.req_x = 8'h3C;
    bus.req_y = 8'h5A;
    bus.req_carry = 1'b1;
    bus.req_shamt = 3'd1;
    bus.sweep_start = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.sweep_start = 1'b0;
    n = 0;
    while (!(bus.rsp_valid === 1'b1 && bus.rsp_op === 3'd4)
           && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_op !== 3'd4 || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reach got op=%0d v=%b need 4 1",
               bus.rsp_op, bus.rsp_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.sweep_busy !== 1'b0
        || bus.alu_operation !== 3'd0 || bus.alu_x !== 8'h00
        || bus.alu_y !== 8'h00 || bus.alu_shamt !== 3'd0
        || bus.alu_carry_in !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got v=%b b=%b op=%0d x=%h need 0",
               bus.rsp_valid, bus.sweep_busy,
               bus.alu_operation, bus.alu_x);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got %b need 1", bus.req_ready);
    end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL rstmid_silent got %0d responses need 0", extra);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    bus.req_op = 3'd1;
    bus.req_x = 8'h80;
    bus.req_y = 8'h80;
    bus.req_shamt = 3'd0;
    bus.req_carry = 1'b0;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    sb.push_back(mk_exp(3'd1, 3'd0, 8'h80, 8'h80, 1'b0, 1'b0));
    @(negedge clk);
    bus.req_op = 3'd6;
    bus.req_x = 8'hA5;
    bus.req_y = 8'h0C;
    bus.req_shamt = 3'd3;
    sb.push_back(mk_exp(3'd6, 3'd3, 8'hA5, 8'h0C, 1'b0, 1'b0));
    checks++;
    if (bus.alu_operation !== 3'd1 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first got op=%0d rdy=%b need 1 0",
               bus.alu_operation, bus.req_ready);
    end
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (bus.rsp_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_timeout[%0d] got v=0 need 1", r);
      end else begin
        e = sb.pop_front();
        if (bus.rsp_op !== e.op || bus.rsp_result !== e.res
            || bus.rsp_overflow !== e.ovf
            || bus.rsp_zero !== e.zero) begin
          errors++;
          $display("FAIL b2b_rsp[%0d] got op=%0d r=%h need op=%0d r=%h",
                   r, bus.rsp_op, bus.rsp_result, e.op, e.res);
        end
      end
      @(negedge clk);
      if (r == 0) begin
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle got rdy=%b v=%b need 1 0",
                   bus.req_ready, bus.rsp_valid);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.alu_operation !== 3'd6 || bus.alu_x !== 8'hA5
            || bus.req_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_second got op=%0d x=%h rdy=%b need 6 a5 0",
                   bus.alu_operation, bus.alu_x, bus.req_ready);
        end
      end
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_end got v=%b left=%0d need 0 0",
               bus.rsp_valid, sb.size());
    end
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_sweep();
    test_priority();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout need finish");
    $fatal(1);
  end

endmodule
